// File: rtl/led_matrix_pkg.sv
// Shared glyph codes, scan-state encoding and the 8x8 glyph bitmap function
// for the LED-matrix scanner.
package led_matrix_pkg;

    localparam logic [3:0] GLYPH_BLANK = 4'hA;
    localparam logic [3:0] GLYPH_FRAME = 4'hF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ON    = 2'd1;
    localparam logic [1:0] ST_BLANK = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ON    = ST_ON,
        BLANK = ST_BLANK
    } scan_state_t;

    // Active-high bitmap, bit 7 = leftmost column. Digits are 5x7 in columns 5..1,
    // rows 1..7; each digit is packed as seven 5-bit rows, row 1 in the top bits.
    function automatic logic [7:0] glyph_row(input logic [3:0] code, input logic [2:0] idx);
        logic [34:0] bm;
        logic [34:0] sh;
        bm = '0;
        case (code)
            4'd0: bm = {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
            4'd1: bm = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
            4'd2: bm = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
            4'd3: bm = {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
            4'd4: bm = {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
            4'd5: bm = {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
            4'd6: bm = {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
            4'd7: bm = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
            4'd8: bm = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
            4'd9: bm = {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
            default: bm = '0;
        endcase
        if (code == GLYPH_FRAME) begin
            glyph_row = (idx == 3'd0 || idx == 3'd7) ? 8'hFF : 8'h81;
        end else if (idx == 3'd0) begin
            glyph_row = 8'h00;
        end else begin
            sh = bm >> (5 * (7 - int'(idx)));
            glyph_row = {2'b00, sh[4:0], 1'b0};
        end
    endfunction

endpackage

// File: rtl/led_glyph_rom.sv
// Combinational glyph lookup: (code, row index) -> active-high 8-bit column bitmap.
module led_glyph_rom
    import led_matrix_pkg::*;
(
    input  logic [3:0] code,
    input  logic [2:0] row_idx,
    output logic [7:0] bitmap
);

    assign bitmap = glyph_row(code, row_idx);

endmodule

// File: rtl/led_matrix_scan.sv
// Time-multiplexed 8x8 LED-matrix scanner with inter-row blanking, frame-locked
// glyph latching and frame-synchronous blink.
//
//   state | meaning
//   IDLE  | scan stopped, outputs dark, waiting for en
//   ON    | row_idx driven, columns show the glyph row for DWELL cycles
//   BLANK | everything off for BLANK_CYC cycles to stop ghosting
module led_matrix_scan
    import led_matrix_pkg::*;
#(
    parameter int DWELL       = 16,
    parameter int BLANK_CYC   = 2,
    parameter int BLINK_LOG2  = 5,
    parameter int ROW_ACT_LOW = 1,
    parameter int COL_ACT_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       sel_alt,
    input  logic [3:0] code_a,
    input  logic [3:0] code_b,
    input  logic       blink,
    output logic [7:0] row,
    output logic [7:0] column,
    output logic       frame_start
);

    localparam int CNT_MAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [7:0] ROW_IDLE = (ROW_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [7:0] COL_IDLE = (COL_ACT_LOW != 0) ? 8'hFF : 8'h00;

    scan_state_t           state;
    logic [2:0]            row_idx;
    logic [CNT_W-1:0]      dwell_cnt;
    logic [BLINK_LOG2-1:0] frame_cnt;
    logic [3:0]            glyph;
    logic [7:0]            bitmap;
    logic [3:0]            code_sel;
    logic                  row_end;
    logic                  scan_on;
    logic                  blanked;

    assign code_sel = sel_alt ? code_b : code_a;

    // Row boundary: last ON cycle when blanking is disabled, otherwise last BLANK cycle.
    assign row_end = (dwell_cnt == '0) &&
                     ((state == BLANK) || (state == ON && BLANK_CYC == 0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            row_idx   <= '0;
            dwell_cnt <= '0;
            frame_cnt <= '0;
            glyph     <= GLYPH_FRAME;
        end else if (!en) begin
            state     <= IDLE;
            row_idx   <= '0;
            dwell_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state     <= ON;
                    row_idx   <= '0;
                    dwell_cnt <= DWELL_LOAD;
                    glyph     <= code_sel;
                end
                ON: begin
                    if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end else if (BLANK_CYC == 0) begin
                        dwell_cnt <= DWELL_LOAD;
                    end else begin
                        state     <= BLANK;
                        dwell_cnt <= BLANK_LOAD;
                    end
                end
                BLANK: begin
                    if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end else begin
                        state     <= ON;
                        dwell_cnt <= DWELL_LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
            if (state != IDLE && row_end) begin
                row_idx <= row_idx + 1'b1;
                if (row_idx == 3'd7) begin
                    glyph     <= code_sel;
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    led_glyph_rom u_rom (
        .code    (glyph),
        .row_idx (row_idx),
        .bitmap  (bitmap)
    );

    // en gates the output stage directly so dropping it darkens the matrix on the next edge.
    assign scan_on = en && (state == ON);
    assign blanked = blink && frame_cnt[BLINK_LOG2-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row         <= ROW_IDLE;
            column      <= COL_IDLE;
            frame_start <= 1'b0;
        end else begin
            row         <= scan_on ? ((8'b1 << row_idx) ^ ROW_IDLE) : ROW_IDLE;
            column      <= (scan_on && !blanked) ? (bitmap ^ COL_IDLE) : COL_IDLE;
            frame_start <= scan_on && (row_idx == 3'd0) && (dwell_cnt == DWELL_LOAD);
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Scoreboard bench for led_matrix_scan: two instances (with and without blanking,
// both row polarities) against a frame-position reference model.
module tb_led_matrix_scan;

    localparam int DWELL = 4;
    localparam int BL    = 2;

    typedef struct packed {
        logic [7:0] row;
        logic [7:0] col;
        logic       fs;
    } exp_t;

    localparam logic [4:0] FONT [10][7] = '{
        '{5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E},
        '{5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E},
        '{5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F},
        '{5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E},
        '{5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02},
        '{5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E},
        '{5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E},
        '{5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08},
        '{5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E},
        '{5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C}
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       sel_alt = 1'b0;
    logic       blink = 1'b0;
    logic [3:0] code_a = 4'h1;
    logic [3:0] code_b = 4'h0;
    logic [7:0] row_a, col_a, row_b, col_b;
    logic       fs_a, fs_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Model state per instance: running flag, position in frame, frames shown, latched glyph.
    bit         m_run [2];
    int         m_pos [2];
    int         m_fc  [2];
    logic [3:0] m_gl  [2];
    int         per   [2] = '{5, 4};
    bit         rlow  [2] = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    led_matrix_scan #(.DWELL(4), .BLANK_CYC(1), .BLINK_LOG2(2), .ROW_ACT_LOW(1), .COL_ACT_LOW(1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .sel_alt(sel_alt), .code_a(code_a), .code_b(code_b),
        .blink(blink), .row(row_a), .column(col_a), .frame_start(fs_a)
    );

    led_matrix_scan #(.DWELL(4), .BLANK_CYC(0), .BLINK_LOG2(2), .ROW_ACT_LOW(0), .COL_ACT_LOW(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .sel_alt(sel_alt), .code_a(code_a), .code_b(code_b),
        .blink(blink), .row(row_b), .column(col_b), .frame_start(fs_b)
    );

    function automatic logic [7:0] ref_bitmap(input logic [3:0] c, input int r);
        if (c == 4'hF) return (r == 0 || r == 7) ? 8'hFF : 8'h81;
        if (c > 4'd9 || r == 0) return 8'h00;
        return {2'b00, FONT[c][r-1], 1'b0};
    endfunction

    function automatic exp_t idle_out(input int i);
        exp_t e;
        e.row = rlow[i] ? 8'hFF : 8'h00;
        e.col = 8'hFF;
        e.fs  = 1'b0;
        return e;
    endfunction

    function automatic exp_t predict(input int i);
        exp_t e;
        int   r;
        int   ph;
        e  = idle_out(i);
        r  = m_pos[i] / per[i];
        ph = m_pos[i] % per[i];
        if (!rst && en && m_run[i] && ph < DWELL) begin
            e.row = e.row ^ (8'h01 << r);
            if (!(blink && m_fc[i][BL-1])) e.col = ~ref_bitmap(m_gl[i], r);
            e.fs = (m_pos[i] == 0);
        end
        return e;
    endfunction

    task automatic model_step();
        q_a.push_back(predict(0));
        q_b.push_back(predict(1));
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_run[i] = 1'b0; m_pos[i] = 0; m_fc[i] = 0; m_gl[i] = 4'hF;
            end else if (!en) begin
                m_run[i] = 1'b0;
            end else if (!m_run[i]) begin
                m_run[i] = 1'b1; m_pos[i] = 0; m_gl[i] = sel_alt ? code_b : code_a;
            end else begin
                m_pos[i]++;
                if (m_pos[i] == 8 * per[i]) begin
                    m_pos[i] = 0;
                    m_fc[i]++;
                    m_gl[i] = sel_alt ? code_b : code_a;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) cycle();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            n_chk++;
            if ({row_a, col_a, fs_a} !== e) begin
                n_fail++;
                $display("FAIL scan_a t=%0t: got row=%h col=%h fs=%b, expected row=%h col=%h fs=%b",
                         $time, row_a, col_a, fs_a, e.row, e.col, e.fs);
            end
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            n_chk++;
            if ({row_b, col_b, fs_b} !== e) begin
                n_fail++;
                $display("FAIL scan_b t=%0t: got row=%h col=%h fs=%b, expected row=%h col=%h fs=%b",
                         $time, row_b, col_b, fs_b, e.row, e.col, e.fs);
            end
        end
    end

    initial begin
        run_cycles(4);
        rst = 1'b0;
        run_cycles(13);
        code_a = 4'h2;
        run_cycles(80);
        code_a = 4'hF;
        run_cycles(45);
        sel_alt = 1'b1; code_b = 4'h7;
        run_cycles(45);
        blink = 1'b1;
        run_cycles(210);
        blink = 1'b0;
        run_cycles(17);
        en = 1'b0;
        run_cycles(6);
        en = 1'b1;
        run_cycles(50);

        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 19) == 0) code_a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) code_b = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) sel_alt = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) blink = 1'($urandom_range(0, 1));
            en = ($urandom_range(0, 99) != 0);
            cycle();
        end

        // Asynchronous reset mid-row: outputs must go dark before the next clock edge.
        en = 1'b1; blink = 1'b0; sel_alt = 1'b0; code_a = 4'h8;
        run_cycles(23);
        @(posedge clk);
        model_step();
        #2;
        rst = 1'b1;
        q_a[q_a.size()-1] = idle_out(0);
        q_b[q_b.size()-1] = idle_out(1);
        run_cycles(3);
        rst = 1'b0;
        run_cycles(100);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
